// File: rtl/data_cache_pkg.sv
// Shared types and geometry helpers for the direct-mapped data cache.
package cache_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RMISS = 2'd1,
      ST_WTHRU = 2'd2,
      ST_DONE  = 2'd3
   } cache_state_t;

   localparam int DEF_SETS   = 64;
   localparam int DEF_ADDR_W = 32;
   localparam int IDX_W      = $clog2(DEF_SETS);
   localparam int TAG_W      = DEF_ADDR_W - IDX_W - 2;

   function automatic int idx_bits(input int sets);
      return $clog2(sets);
   endfunction

   // Tag is whatever remains above the index and the 2-bit byte offset.
   function automatic int tag_bits(input int aw, input int sets);
      return aw - $clog2(sets) - 2;
   endfunction

endpackage

// File: rtl/data_cache_if.sv
// CPU-side and memory-side bundles of the data cache.
interface data_cache_cpu_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0] addr_i;
   logic [DATA_WIDTH-1:0] wdata_i;
   logic                  re_i;
   logic                  we_i;
   logic                  byte_op_i;
   logic [DATA_WIDTH-1:0] rdata_o;
   logic                  stall_o;

   modport master (
      output addr_i, wdata_i, re_i, we_i, byte_op_i,
      input  rdata_o, stall_o
   );

   modport slave (
      input  addr_i, wdata_i, re_i, we_i, byte_op_i,
      output rdata_o, stall_o
   );
endinterface

interface data_cache_mem_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0] mem_addr_o;
   logic [DATA_WIDTH-1:0] mem_wdata_o;
   logic                  mem_re_o;
   logic                  mem_we_o;
   logic                  mem_byte_o;
   logic [DATA_WIDTH-1:0] mem_rdata_i;
   logic                  mem_ready_i;

   modport master (
      output mem_addr_o, mem_wdata_o, mem_re_o,
      output mem_we_o, mem_byte_o,
      input  mem_rdata_i, mem_ready_i
   );

   modport slave (
      input  mem_addr_o, mem_wdata_o, mem_re_o,
      input  mem_we_o, mem_byte_o,
      output mem_rdata_i, mem_ready_i
   );
endinterface

// File: rtl/data_cache_store.sv
// Valid bits, tag array and data array: one read port, one byte-enabled write port.
module data_cache_store #(
   parameter int DATA_WIDTH = 32,
   parameter int SETS       = 64,
   parameter int TAG_W      = 24
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [$clog2(SETS)-1:0] i_ridx,
   output logic                    o_valid,
   output logic [TAG_W-1:0]        o_tag,
   output logic [DATA_WIDTH-1:0]   o_data,
   input  logic                    i_we,
   input  logic [$clog2(SETS)-1:0] i_widx,
   input  logic [TAG_W-1:0]        i_wtag,
   input  logic [DATA_WIDTH-1:0]   i_wdata,
   input  logic [DATA_WIDTH/8-1:0] i_be
);

   localparam int NB = DATA_WIDTH / 8;

   logic [SETS-1:0]       r_valid;
   logic [TAG_W-1:0]      r_tag  [SETS];
   logic [DATA_WIDTH-1:0] r_data [SETS];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= '0;
      end else if (i_we) begin
         r_valid[i_widx] <= 1'b1;
      end
   end

   // Arrays hold no reset; a cleared valid bit hides stale contents.
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_tag[i_widx] <= i_wtag;
         for (int b = 0; b < NB; b++) begin
            if (i_be[b]) begin
               r_data[i_widx][8*b +: 8] <= i_wdata[8*b +: 8];
            end
         end
      end
   end

   assign o_valid = r_valid[i_ridx];
   assign o_tag   = r_tag[i_ridx];
   assign o_data  = r_data[i_ridx];

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache
// with one-word lines between the memory stage and data memory.
module data_cache #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int SETS       = 64
) (
   input  logic             clk,
   input  logic             rst,
   data_cache_cpu_if.slave  cpu,
   data_cache_mem_if.master mem
);

   import cache_pkg::*;

   localparam int IB = idx_bits(SETS);
   localparam int TW = tag_bits(ADDR_WIDTH, SETS);
   localparam int NB = DATA_WIDTH / 8;

   cache_state_t r_state;
   cache_state_t w_next;

   logic [IB-1:0]         w_idx;
   logic [TW-1:0]         w_tag;
   logic                  w_valid;
   logic [TW-1:0]         w_rtag;
   logic [DATA_WIDTH-1:0] w_line;
   logic                  w_hit;
   logic                  w_idle;
   logic                  w_rmiss;
   logic                  w_wthru;
   logic                  w_fill;
   logic                  w_wupd;
   logic                  w_we;
   logic [DATA_WIDTH-1:0] w_wdata;
   logic [NB-1:0]         w_be;
   logic [NB-1:0]         w_lane;
   logic [DATA_WIDTH-1:0] w_shift;
   logic [DATA_WIDTH-1:0] w_load;

   assign w_idx = cpu.addr_i[IB+1:2];
   assign w_tag = cpu.addr_i[ADDR_WIDTH-1:IB+2];
   assign w_hit = w_valid && (w_rtag == w_tag);

   assign w_idle  = (r_state == ST_IDLE);
   assign w_rmiss = (r_state == ST_RMISS);
   assign w_wthru = (r_state == ST_WTHRU);

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         ST_IDLE: begin
            if (cpu.we_i) begin
               w_next = ST_WTHRU;
            end else if (cpu.re_i && !w_hit) begin
               w_next = ST_RMISS;
            end
         end
         ST_RMISS: begin
            if (mem.mem_ready_i) w_next = ST_IDLE;
         end
         ST_WTHRU: begin
            if (mem.mem_ready_i) w_next = ST_DONE;
         end
         ST_DONE: w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Reset must win over a completing transfer so nothing lands in the arrays.
   assign w_fill = w_rmiss && mem.mem_ready_i && !rst;
   assign w_wupd = w_wthru && mem.mem_ready_i && w_hit && !rst;
   assign w_we   = w_fill || w_wupd;

   assign w_lane = {{(NB-1){1'b0}}, 1'b1} << cpu.addr_i[1:0];

   always_comb begin
      w_wdata = cpu.wdata_i;
      w_be    = '1;
      if (w_fill) begin
         w_wdata = mem.mem_rdata_i;
      end else if (cpu.byte_op_i) begin
         w_wdata = {NB{cpu.wdata_i[7:0]}};
         w_be    = w_lane;
      end
   end

   data_cache_store #(
      .DATA_WIDTH (DATA_WIDTH),
      .SETS       (SETS),
      .TAG_W      (TW)
   ) u_store (
      .clk     (clk),
      .rst     (rst),
      .i_ridx  (w_idx),
      .o_valid (w_valid),
      .o_tag   (w_rtag),
      .o_data  (w_line),
      .i_we    (w_we),
      .i_widx  (w_idx),
      .i_wtag  (w_tag),
      .i_wdata (w_wdata),
      .i_be    (w_be)
   );

   assign w_shift = w_line >> {cpu.addr_i[1:0], 3'b000};

   always_comb begin
      w_load = '0;
      if (cpu.re_i && w_hit && !rst) begin
         if (cpu.byte_op_i) begin
            w_load = {{(DATA_WIDTH-8){1'b0}}, w_shift[7:0]};
         end else begin
            w_load = w_line;
         end
      end
   end

   assign cpu.rdata_o = w_load;
   assign cpu.stall_o = !rst && (w_rmiss || w_wthru
                      || (w_idle && cpu.we_i)
                      || (w_idle && cpu.re_i && !w_hit));

   // Request fields are driven straight from the held CPU inputs.
   always_comb begin
      mem.mem_addr_o  = '0;
      mem.mem_wdata_o = '0;
      mem.mem_re_o    = 1'b0;
      mem.mem_we_o    = 1'b0;
      mem.mem_byte_o  = 1'b0;
      if (w_rmiss) begin
         mem.mem_re_o   = 1'b1;
         mem.mem_addr_o = {cpu.addr_i[ADDR_WIDTH-1:2], 2'b00};
      end else if (w_wthru) begin
         mem.mem_we_o    = 1'b1;
         mem.mem_addr_o  = cpu.addr_i;
         mem.mem_wdata_o = cpu.wdata_i;
         mem.mem_byte_o  = cpu.byte_op_i;
      end
   end

endmodule

// File: doc/data_cache.md
# data_cache

Direct-mapped, write-through, no-write-allocate data cache between the CPU memory stage and the backing data memory. It serves memory-stage loads and stores from one-word lines. It raises `stall` while it waits on the backing memory, and the pipeline holds every stage while `stall` is high. Its CPU-side view is the same word/byte access used by the memory stage: address, write data, write enable and byte-op flag.

## Interface
- `DATA_WIDTH`, default 32: data word width.
- `ADDR_WIDTH`, default 32: byte address width.
- `SETS`, default 64: number of lines; must be a power of two; one word per line.
- `clk` input, 1 bit: the only clock; all state updates on its rising edge.
- `rst` input, 1 bit: reset is synchronous and active-high.
- `addr_i` input, `ADDR_WIDTH`: CPU byte address (ALU result of the memory stage).
- `wdata_i` input, `DATA_WIDTH`: CPU store data.
- `re_i` input, 1 bit: load request.
- `we_i` input, 1 bit: store request.
- `byte_op_i` input, 1 bit: 1 selects a byte access, 0 selects a word access.
- `rdata_o` output, `DATA_WIDTH`: load data; a byte load is zero-extended.
- `stall_o` output, 1 bit: the pipeline must hold the current request.
- `mem_addr_o` output, `ADDR_WIDTH`: backing-memory address.
- `mem_wdata_o` output, `DATA_WIDTH`: backing-memory write data.
- `mem_re_o` output, 1 bit: backing-memory read request.
- `mem_we_o` output, 1 bit: backing-memory write request.
- `mem_byte_o` output, 1 bit: backing-memory byte-write flag.
- `mem_rdata_i` input, `DATA_WIDTH`: backing-memory read word.
- `mem_ready_i` input, 1 bit: backing memory has completed the current request.

## Operation
- Address split:
  - byte offset = `addr[1:0]`
  - index = `addr[IB+1:2]`, where IB = log2(SETS)
  - tag = remaining upper bits
- hit = `valid[index]` and the stored tag equals the request tag.
- States:
  - IDLE
  - RMISS: read fill in progress
  - WTHRU: write-through in progress
  - DONE: one-cycle completion of a store
- IDLE transitions:
  - `we_i` → WTHRU. A store wins over `re_i` when both are high.
  - `re_i` and hit → stays in IDLE; `rdata_o` is valid combinationally in the same cycle.
  - `re_i` and miss → RMISS.
- RMISS:
  - `mem_re_o`=1.
  - `mem_addr_o` = word-aligned `addr_i`.
  - On `mem_ready_i`: write data, tag and valid into the line, then go to IDLE. The held load hits on the next cycle.
- WTHRU:
  - `mem_we_o`=1, `mem_addr_o`=`addr_i`, `mem_wdata_o`=`wdata_i`, `mem_byte_o`=`byte_op_i`.
  - On `mem_ready_i`: if the request hits, update the line (the whole word, or the byte lane at `addr[1:0]`, taken from `wdata_i[7:0]`), then go to DONE.
  - A store miss never allocates a line.
- DONE: `stall_o`=0 and no new store is launched; the next state is IDLE.
- `stall_o` = (state is RMISS or WTHRU) OR (IDLE and `we_i`) OR (IDLE and `re_i` and miss).
- The backing-memory request (`mem_re_o`/`mem_we_o` plus address and data) is held stable until the cycle in which `mem_ready_i` is sampled high.
- A byte load selects the lane at `addr[1:0]` and zero-extends it.
- With no `re_i`, `rdata_o`=0.

## Timing
- Reset, same edge:
  - state = IDLE
  - all valid bits cleared
  - `stall_o`, `mem_re_o`, `mem_we_o`, `mem_byte_o` = 0
  - `mem_addr_o`, `mem_wdata_o`, `rdata_o` = 0
- Tag and data arrays are not reset.
- Reset during RMISS or WTHRU abandons the transfer. Request lines are low on the first post-reset cycle, no line is written, and a late `mem_ready_i` is ignored.
- Load hit: 0 stall cycles.
- Load miss: stall for 1 + N cycles, where N = cycles until `mem_ready_i`; data is returned in the following IDLE cycle.
- Store: stall for 1 + N cycles, then the DONE cycle releases the pipeline.
- `mem_ready_i` is ignored while in IDLE or DONE.
- Same index, different tag: a read fill replaces the line unconditionally (direct-mapped).
- Index wrap: address 4·SETS maps to index 0.

## Structure
- Package `cache_pkg`:
  - state enum `cache_state_t` (IDLE, RMISS, WTHRU, DONE)
  - localparams for index and tag widths, derived from `SETS` and `ADDR_WIDTH`
- Sub-module `data_cache_store`:
  - valid flop vector with synchronous clear
  - tag array and data array
  - one read port and one write port with byte-lane enables
- The top module holds the FSM, the hit compare and the request muxing.

## Test plan
- Reset, then load word at 0x100 with memory returning 0xDEADBEEF after 2 cycles → `stall_o` high for 3 cycles; `rdata_o`=0xDEADBEEF; a repeat load of 0x100 has 0 stall cycles and no `mem_re_o`.
- Store word 0x12345678 to cached 0x100 → one `mem_we_o` transfer; DONE cycle has `stall_o`=0; a following load hits with 0x12345678.
- Store byte 0xAA to 0x102 on a hit line holding 0x12345678 → `mem_byte_o`=1; line becomes 0x12AA5678; byte load of 0x102 returns 0x000000AA.
- Store to uncached 0x200 → write-through only; a following load of 0x200 misses and issues `mem_re_o`.
- Load 0x100 then load 0x100+4·SETS (conflict) → second load misses and evicts the line; reloading 0x100 misses again.
- Assert `rst` during RMISS with `mem_ready_i` arriving a cycle later → no fill; load of the same address misses; `stall_o`=0 right after reset.
